uart_banner_scroller: RTL
=========================

UART_BANNER_SCROLLER -- requirements
Module: uart_banner_scroller

Interface
REQ-001 SHALL have parameter N_DIGITS, default 8, number of 7-seg character positions driven.
REQ-002 SHALL have parameter DEPTH, default 32, maximum message length in characters.
REQ-003 SHALL have parameter TICK_DIV, default 25_000_000, clk cycles per scroll step.
REQ-004 SHALL have parameter CHAR_W, default 5, width of one character code.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data holds a received byte.
REQ-008 rx_data  input  8  received ASCII byte.
REQ-009 tx_ready  input  1  downstream UART TX can accept a byte.
REQ-010 tx_valid  output  1  echo byte valid.
REQ-011 tx_data  output  8  echo byte.
REQ-012 char_out  output  N_DIGITS*CHAR_W  displayed codes; slice [CHAR_W*(N_DIGITS-1) +: CHAR_W] is the leftmost digit.
REQ-013 msg_len  output  $clog2(DEPTH+1)  length of the message currently displayed.
REQ-014 overflow  output  1  sticky: a byte was dropped because the receive bank was full.

Function
REQ-015 Two banks of DEPTH codes SHALL exist: receive bank (filled) and display bank (scrolled); commit swaps bank roles in one cycle, no copy.
REQ-016 Each rx_valid byte other than CR (0x0D), LF (0x0A), ESC (0x1B) SHALL be encoded via ascii_to_code and appended at receive index rx_cnt, rx_cnt incrementing.
REQ-017 Byte arriving with rx_cnt==DEPTH SHALL be dropped and overflow set; overflow clears only on ESC or reset.
REQ-018 CR or LF with rx_cnt>0 SHALL commit: swap banks, msg_len<=rx_cnt, rx_cnt<=0, pos<=0, tick counter<=0; with rx_cnt==0 SHALL be ignored (CRLF pairs give one commit).
REQ-019 ESC SHALL clear rx_cnt and overflow; display bank and msg_len unaffected.
REQ-020 States: EMPTY (msg_len==0, all digits BLANK), STATIC (1<=msg_len<=N_DIGITS, message left-aligned, remaining digits BLANK, pos frozen at 0), SCROLL (msg_len>N_DIGITS); state follows each commit.
REQ-021 In SCROLL, virtual string V = message followed by N_DIGITS BLANKs, period P=msg_len+N_DIGITS; leftmost+k digit shows V[(pos+k) mod P].
REQ-022 Tick counter SHALL count 0..TICK_DIV-1 and wrap; at TICK_DIV-1 in SCROLL, pos<=(pos==P-1)?0:pos+1.
REQ-023 char_out SHALL be registered, updating exactly one cycle after the commit or tick causing the change.
REQ-024 Commit and tick in the same cycle: commit wins (pos=0, counter=0); byte append and tick in the same cycle both take effect.
REQ-025 Codes outside the package table SHALL map to BLANK (31); lowercase a-f map as uppercase.

Reset
REQ-026 During rst_n low: char_out all BLANK, msg_len 0, overflow 0, tx_valid 0, tx_data 0, rx_cnt 0, pos 0, counter 0, state EMPTY, bank select 0.
REQ-027 Reset mid-reception or mid-scroll SHALL discard all buffered content; first accepted byte after release is index 0.

Configuration
REQ-028 Macro UART_BANNER_ECHO_EN defined: every rx_valid byte (incl. CR/LF/ESC, dropped bytes) SHALL be echoed; tx_valid held until tx_ready; if a byte arrives while tx_valid&&!tx_ready the new echo is discarded (receive path unaffected).
REQ-029 Macro undefined: tx_valid and tx_data SHALL be constant 0; no echo register synthesised.

Structure
REQ-030 Package uart_banner_pkg SHALL hold CHAR_W, code constants (0-9 digits, 10-15 A-F, 16 H, 17 L, 18 P, 19 U, 20 n, 21 o, 22 r, 23 t, 24 '-', 25 '_', 31 BLANK), CR/LF/ESC constants, function ascii_to_code.
REQ-031 Sub-module banner_tick_gen (parametrised divider, sync clear input, one-cycle tick output) SHALL implement the scroll timer.

Verification
REQ-032 "12AB",CR, N_DIGITS=8 -> next cycle after commit char_out = 1,2,A,B,BLANK x4; msg_len=4; no scrolling after 3 ticks.
REQ-033 "0123456789",LF, TICK_DIV=4 -> leftmost digit 0 after commit, 1 after first tick, 9 after 9 ticks, 0 again after P=18 ticks.
REQ-034 DEPTH=4, send "ABCDEF" -> overflow=1 after 5th byte; CR -> msg_len=4 shows A,B,C,D; ESC -> overflow=0.
REQ-035 Scrolling 10-char message, send "HELP" without terminator -> display continues unchanged; CR -> STATIC H,E,L,P within one cycle.
REQ-036 With UART_BANNER_ECHO_EN, tx_ready=0, send 'A','B' -> tx_data=0x41 held, 'B' echo lost; tx_ready=1 -> tx_valid drops next cycle; without macro tx_valid stays 0.
REQ-037 Assert rst_n low mid-scroll with 3 bytes pending -> all outputs at reset values; after release, "7",CR shows 7 at leftmost.

Source files
------------

// File: rtl/uart_banner_pkg.sv
// Shared constants, display-state type and the ASCII-to-7-seg character code map
// for the UART banner scroller.
package uart_banner_pkg;

  localparam int CHAR_W = 5;

  localparam logic [CHAR_W-1:0] C_H     = 5'd16;
  localparam logic [CHAR_W-1:0] C_L     = 5'd17;
  localparam logic [CHAR_W-1:0] C_P     = 5'd18;
  localparam logic [CHAR_W-1:0] C_U     = 5'd19;
  localparam logic [CHAR_W-1:0] C_N     = 5'd20;
  localparam logic [CHAR_W-1:0] C_O     = 5'd21;
  localparam logic [CHAR_W-1:0] C_R     = 5'd22;
  localparam logic [CHAR_W-1:0] C_T     = 5'd23;
  localparam logic [CHAR_W-1:0] C_DASH  = 5'd24;
  localparam logic [CHAR_W-1:0] C_UNDER = 5'd25;
  localparam logic [CHAR_W-1:0] C_BLANK = 5'd31;

  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_LF  = 8'h0A;
  localparam logic [7:0] ASC_ESC = 8'h1B;

  typedef enum logic [1:0] {ST_EMPTY, ST_STATIC, ST_SCROLL} disp_st_t;

  function automatic logic [CHAR_W-1:0] ascii_to_code(input logic [7:0] a);
    logic [CHAR_W-1:0] c;
    c = C_BLANK;
    if (a >= 8'h30 && a <= 8'h39)      c = CHAR_W'(a - 8'h30);
    else if (a >= 8'h41 && a <= 8'h46) c = CHAR_W'(a - 8'h37);
    else if (a >= 8'h61 && a <= 8'h66) c = CHAR_W'(a - 8'h57);
    else begin
      case (a)
        8'h48:   c = C_H;
        8'h4C:   c = C_L;
        8'h50:   c = C_P;
        8'h55:   c = C_U;
        8'h6E:   c = C_N;
        8'h6F:   c = C_O;
        8'h72:   c = C_R;
        8'h74:   c = C_T;
        8'h2D:   c = C_DASH;
        8'h5F:   c = C_UNDER;
        default: c = C_BLANK;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/banner_tick_gen.sv
// Free-running scroll-step divider: counts 0..DIV-1, pulses tick on the last count,
// synchronous clear restarts the period.
module banner_tick_gen #(
  parameter int DIV = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/uart_banner_scroller.sv
// UART-fed 7-segment banner: double-buffered message banks, static or scrolling display.
// Optional byte echo on the TX side is enabled by defining UART_BANNER_ECHO_EN.
module uart_banner_scroller
  import uart_banner_pkg::*;
#(
  parameter int N_DIGITS = 8,
  parameter int DEPTH    = 32,
  parameter int TICK_DIV = 25_000_000,
  parameter int CHAR_W   = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  input  logic                         tx_ready,
  output logic                         tx_valid,
  output logic [7:0]                   tx_data,
  output logic [N_DIGITS*CHAR_W-1:0]   char_out,
  output logic [$clog2(DEPTH+1)-1:0]   msg_len,
  output logic                         overflow
);
  localparam int ML_W = $clog2(DEPTH + 1);
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW   = $clog2(DEPTH + N_DIGITS + 1);
  localparam int IW   = $clog2(DEPTH + 2 * N_DIGITS);
  localparam logic [CHAR_W-1:0] BLK = CHAR_W'(C_BLANK);

  logic [CHAR_W-1:0] bank0 [DEPTH];
  logic [CHAR_W-1:0] bank1 [DEPTH];
  logic              bank_sel;           // selects the display bank
  logic [ML_W-1:0]   rx_cnt, msg_len_q;
  logic [PW-1:0]     pos, period;
  logic              overflow_q, tick;
  disp_st_t          state, state_nxt;

  logic [N_DIGITS-1:0][CHAR_W-1:0] dig_nxt, dig_q;

  logic is_term, is_esc, is_char, full, append, drop, commit, advance;
  logic [CHAR_W-1:0] rx_code;

  assign is_term = (rx_data == ASC_CR) || (rx_data == ASC_LF);
  assign is_esc  = (rx_data == ASC_ESC);
  assign is_char = rx_valid && !is_term && !is_esc;
  assign full    = (rx_cnt == ML_W'(DEPTH));
  assign append  = is_char && !full;
  assign drop    = is_char && full;
  assign commit  = rx_valid && is_term && (rx_cnt != '0);
  assign period  = PW'(msg_len_q) + PW'(N_DIGITS);
  assign advance = tick && (state == ST_SCROLL);
  assign rx_code = CHAR_W'(ascii_to_code(rx_data));

  banner_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (commit),
    .tick  (tick)
  );

  always_comb begin
    state_nxt = state;
    if (commit) state_nxt = (int'(rx_cnt) > N_DIGITS) ? ST_SCROLL : ST_STATIC;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_sel   <= 1'b0;
      rx_cnt     <= '0;
      msg_len_q  <= '0;
      pos        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (append) rx_cnt <= rx_cnt + 1'b1;
      if (rx_valid && is_esc) begin
        rx_cnt     <= '0;
        overflow_q <= 1'b0;
      end else if (drop) begin
        overflow_q <= 1'b1;
      end
      // Commit beats a coincident tick: the new message always starts at pos 0.
      if (commit) begin
        bank_sel  <= ~bank_sel;
        msg_len_q <= rx_cnt;
        rx_cnt    <= '0;
        pos       <= '0;
      end else if (advance) begin
        pos <= (pos == period - 1'b1) ? '0 : pos + 1'b1;
      end
    end
  end

  // Message storage needs no reset; rx_cnt/msg_len gate what is visible.
  always_ff @(posedge clk) begin
    if (append) begin
      if (bank_sel) bank0[AW'(rx_cnt)] <= rx_code;
      else          bank1[AW'(rx_cnt)] <= rx_code;
    end
  end

  // One lane per digit: index into the virtual string message + N_DIGITS blanks.
  for (genvar k = 0; k < N_DIGITS; k++) begin : g_dig
    logic [IW-1:0]     raw, idx;
    logic [CHAR_W-1:0] rd;
    assign raw = IW'(pos) + IW'(k);
    assign idx = (raw >= IW'(period)) ? raw - IW'(period) : raw;
    assign rd  = bank_sel ? bank1[AW'(idx)] : bank0[AW'(idx)];
    assign dig_nxt[N_DIGITS-1-k] = (idx < IW'(msg_len_q)) ? rd : BLK;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dig_q <= {N_DIGITS{BLK}};
    else        dig_q <= dig_nxt;
  end

  assign char_out = dig_q;
  assign msg_len  = msg_len_q;
  assign overflow = overflow_q;

`ifdef UART_BANNER_ECHO_EN
  // A byte arriving while the echo slot is stalled is dropped from the echo only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (rx_valid && (!tx_valid || tx_ready)) begin
      tx_valid <= 1'b1;
      tx_data  <= rx_data;
    end else if (tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
`else
  logic unused_tx_ready;
  assign unused_tx_ready = tx_ready;
  assign tx_valid = 1'b0;
  assign tx_data  = '0;
`endif

endmodule
